cfg_chain_reader: RTL and testbench
===================================

CFG_CHAIN_READER -- requirements
Module: cfg_chain_reader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64: number of configuration flip-flops in the chain to read back, 1..65535.
REQ-002 SHALL have parameter WORD_W, default 8: width of the output word, 1..32.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse begins a readback; ignored while busy=1.
REQ-006 SHALL have port chain_tail, input, 1 bit: serial data from the chain tail flip-flop.
REQ-007 SHALL have port shift_en, output, 1 bit: chain shift enable; the chain advances one bit at each edge where shift_en=1.
REQ-008 SHALL have port ccff_head, output, 1 bit: serial data driven into the chain head.
REQ-009 SHALL have port out_data, output, WORD_W bits: assembled readback word.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a word.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-012 SHALL have port busy, output, 1 bit: a readback is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when the last word is accepted.

Function
REQ-014 SHALL implement the states IDLE, SHIFT, XFER and FIN.
REQ-015 IDLE SHALL go to SHIFT on start=1, clearing bit_cnt (the bits in the current word) and total_cnt (the bits read so far).
REQ-016 In SHIFT, shift_en SHALL be driven combinationally as 1; each edge SHALL capture chain_tail into assembly bit position bit_cnt and increment both counters. The first bit read SHALL go into the LSB.
REQ-017 SHALL go from SHIFT to XFER at the edge where bit_cnt reaches WORD_W or total_cnt reaches CHAIN_LEN; shift_en SHALL be 0 in XFER.
REQ-018 For a final partial word (CHAIN_LEN mod WORD_W != 0), the unused MSBs SHALL be 0.
REQ-019 In XFER, when out_valid=0, or out_valid=1 with out_ready=1:
  - the assembly word SHALL be loaded into out_data and out_valid set at that edge;
  - bit_cnt and the assembly register SHALL be cleared;
  - the next state SHALL be SHIFT if total_cnt<CHAIN_LEN, else FIN.
  Otherwise XFER SHALL hold, stalling the chain.
REQ-020 out_valid SHALL be cleared at the edge where out_valid=1 and out_ready=1 and no new load occurs; out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 In FIN, at the edge where the last word is accepted (out_valid=1 and out_ready=1), done SHALL pulse high for the next single cycle and the state SHALL go to IDLE.
REQ-022 busy SHALL be 1 in SHIFT, XFER and FIN, and 0 in IDLE.
REQ-023 Exactly CHAIN_LEN shift_en cycles SHALL occur per readback, producing ceil(CHAIN_LEN/WORD_W) words.
REQ-024 A start pulse while busy=1 SHALL have no effect; a start coinciding with done SHALL be ignored.
REQ-025 Latency SHALL be: first out_valid WORD_W+1 cycles after start when the consumer is not stalling.

Reset
REQ-026 reset=1 SHALL force state IDLE with all of the following zero: counters, assembly register, out_data, out_valid, busy, done, shift_en and ccff_head.
REQ-027 reset has priority over all other inputs; reset mid-readback SHALL abort with no done pulse, and the chain is left partially shifted.

Configuration
REQ-028 Macro CFG_CHAIN_READER_LOOPBACK_EN SHALL select the chain restore behaviour.
  - Defined: ccff_head SHALL equal chain_tail when shift_en=1, and 0 otherwise, so the chain contents are restored after a full readback.
  - Undefined: ccff_head SHALL be constant 0, so the chain holds all zeros after readback.

Verification
REQ-029 CHAIN_LEN=16, WORD_W=8, chain bits (first out) 1,0,1,1,0,0,0,0, 1,1,1,1,0,0,0,0, out_ready=1 -> words 0x0D then 0x0F, 16 shift_en cycles, done one cycle after the second accept.
REQ-030 CHAIN_LEN=10, WORD_W=8, all chain bits 1 -> words 0xFF then 0x03, 10 shift_en cycles.
REQ-031 out_ready held 0 for 5 cycles after the first word -> shift_en=0 and out_data stable throughout; readback resumes after accept with no lost bits.
REQ-032 start pulsed mid-readback -> ignored, word count unchanged; reset pulsed mid-SHIFT -> all outputs 0 next cycle, no done.
REQ-033 With LOOPBACK_EN, chain preloaded 0xA5C3 -> after readback the chain reads 0xA5C3 on a second readback; without it, the second readback returns 0x0000.

Source files
------------

// File: rtl/cfg_chain_reader.sv
// Reads back a serial configuration chain and assembles the bits LSB-first into WORD_W-bit words.
// Define CFG_CHAIN_READER_LOOPBACK_EN to feed the tail back into the head so the chain is restored.
module cfg_chain_reader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              chain_tail,
  output logic              shift_en,
  output logic              ccff_head,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        o_dbg_state
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam int TW = $clog2(CHAIN_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, XFER, FIN} state_t;

  state_t            r_state;
  logic [BW-1:0]     r_bit_cnt;
  logic [TW-1:0]     r_total_cnt;
  logic [WORD_W-1:0] r_asm;
  logic [WORD_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_done;

  logic [BW-1:0]     w_bit_nxt;
  logic [TW-1:0]     w_total_nxt;
  logic [WORD_W-1:0] w_bit_mask;
  logic              w_shift;
  logic              w_accept;
  logic              w_load;

  // Handshake: a word transfers on every edge where out_valid=1 and out_ready=1;
  // out_data is held stable while out_valid=1 and out_ready=0.
  assign w_shift     = (r_state == SHIFT) && !reset;
  assign w_bit_nxt   = r_bit_cnt + BW'(1);
  assign w_total_nxt = r_total_cnt + TW'(1);
  assign w_bit_mask  = WORD_W'(1) << r_bit_cnt;
  assign w_accept    = r_out_valid && out_ready;
  assign w_load      = (r_state == XFER) && (!r_out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_total_cnt <= '0;
      r_asm       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) r_out_valid <= 1'b0;
      case (r_state)
        // A start landing on the done cycle belongs to the finished readback and is dropped.
        IDLE: if (start && !r_done) begin
          r_bit_cnt   <= '0;
          r_total_cnt <= '0;
          r_asm       <= '0;
          r_state     <= SHIFT;
        end
        SHIFT: begin
          if (chain_tail) r_asm <= r_asm | w_bit_mask;
          r_bit_cnt   <= w_bit_nxt;
          r_total_cnt <= w_total_nxt;
          if (w_bit_nxt == BW'(WORD_W) || w_total_nxt == TW'(CHAIN_LEN)) r_state <= XFER;
        end
        XFER: if (w_load) begin
          r_out_data  <= r_asm;
          r_out_valid <= 1'b1;
          r_bit_cnt   <= '0;
          r_asm       <= '0;
          r_state     <= (r_total_cnt < TW'(CHAIN_LEN)) ? SHIFT : FIN;
        end
        FIN: if (w_accept) begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign shift_en    = w_shift;
`ifdef CFG_CHAIN_READER_LOOPBACK_EN
  assign ccff_head   = w_shift & chain_tail;
`else
  assign ccff_head   = 1'b0;
`endif
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cfg_chain_reader.sv
// Directed bench for cfg_chain_reader: a 16-bit/8-bit instance (a) and a 10-bit/8-bit instance (b)
// each read a modelled chain; words, shift counts and done timing are checked against hand values.
module tb_cfg_chain_reader;

`ifdef CFG_CHAIN_READER_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  logic out_ready = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance a: CHAIN_LEN=16, WORD_W=8
  logic       start_a = 1'b0, tail_a, sh_en_a, head_a, valid_a, busy_a, done_a;
  logic [7:0] data_a;
  logic [1:0] st_a;
  logic [15:0] chain_a = '0, ld_val_a = '0;
  logic        ld_a = 1'b0;

  cfg_chain_reader #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .chain_tail(tail_a),
    .shift_en(sh_en_a), .ccff_head(head_a), .out_data(data_a), .out_valid(valid_a),
    .out_ready(out_ready), .busy(busy_a), .done(done_a), .o_dbg_state(st_a));

  // instance b: CHAIN_LEN=10, WORD_W=8
  logic       start_b = 1'b0, tail_b, sh_en_b, head_b, valid_b, busy_b, done_b;
  logic [7:0] data_b;
  logic [1:0] st_b;
  logic [9:0] chain_b = '0, ld_val_b = '0;
  logic       ld_b = 1'b0;

  cfg_chain_reader #(.CHAIN_LEN(10), .WORD_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .chain_tail(tail_b),
    .shift_en(sh_en_b), .ccff_head(head_b), .out_data(data_b), .out_valid(valid_b),
    .out_ready(out_ready), .busy(busy_b), .done(done_b), .o_dbg_state(st_b));

  // chain models: bit 0 is the tail, the head enters at the top
  assign tail_a = chain_a[0];
  assign tail_b = chain_b[0];
  always @(posedge clk) begin
    if (ld_a) chain_a <= ld_val_a;
    else if (sh_en_a) chain_a <= {head_a, chain_a[15:1]};
    if (ld_b) chain_b <= ld_val_b;
    else if (sh_en_b) chain_b <= {head_b, chain_b[9:1]};
  end

  // scoreboard: accepted words and event counters
  logic [7:0] exp_q[$];
  logic [7:0] words_a[$];
  logic [7:0] words_b[$];
  int sh_n_a = 0, sh_n_b = 0, done_n_a = 0, done_n_b = 0;
  int acc_cyc_a = 0, done_cyc_a = 0;
  always @(posedge clk) begin
    if (sh_en_a) sh_n_a++;
    if (sh_en_b) sh_n_b++;
    if (valid_a && out_ready) begin words_a.push_back(data_a); acc_cyc_a = cyc; end
    if (valid_b && out_ready) words_b.push_back(data_b);
    if (done_a) begin done_n_a++; done_cyc_a = cyc; end
    if (done_b) done_n_b++;
  end

  int total = 0;
  int bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input bit sel, input logic [15:0] v);
    if (sel) begin ld_val_b = v[9:0]; ld_b = 1'b1; end
    else begin ld_val_a = v; ld_a = 1'b1; end
    step();
    ld_a = 1'b0;
    ld_b = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if ((sel ? done_b : done_a) === 1'b1) begin ok = 1'b1; break; end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic run(input bit sel, input string tag);
    step();
    pulse_start(sel);
    wait_done(sel, tag);
  endtask

  // compares the words accepted since index base against the expected queue
  task automatic check_words(input bit sel, input int base, input string tag);
    int n;
    n = sel ? words_b.size() : words_a.size();
    check({tag, "_count"}, n - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < n; i++)
      check($sformatf("%s_w%0d", tag, i), sel ? words_b[base + i] : words_a[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  int w0, s0, d0;
  logic [7:0] held;

  initial begin
    // reset state
    repeat (3) step();
    reset = 1'b0;
    check("rst_valid_a", valid_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_shen_a", sh_en_a, 0);
    check("rst_head_a", head_a, 0);
    check("rst_data_a", data_a, 0);
    check("rst_state_a", st_a, 0);
    check("rst_busy_b", busy_b, 0);

    // two words with latency check, start on the done cycle ignored
    preload(0, 16'h0F0D);
    w0 = words_a.size(); s0 = sh_n_a; d0 = done_n_a;
    pulse_start(0);
    check("busy_after_start", busy_a, 1);
    repeat (8) step();
    check("lat_not_yet", valid_a, 0);
    check("xfer_shen", sh_en_a, 0);
    step();
    check("lat_valid", valid_a, 1);
    check("lat_data", data_a, 8'h0D);
    wait_done(0, "r1_timeout");
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("start_on_done", busy_a, 0);
    step();
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0F);
    check_words(0, w0, "r1");
    check("r1_shifts", sh_n_a - s0, 16);
    check("r1_done_n", done_n_a - d0, 1);
    check("r1_done_lag", done_cyc_a - acc_cyc_a, 1);
    check("r1_chain", chain_a, LB ? 16'h0F0D : 16'h0000);

    // consumer stall after the first word
    preload(0, 16'h1234);
    w0 = words_a.size(); s0 = sh_n_a;
    out_ready = 1'b0;
    pulse_start(0);
    for (int i = 0; i < 30 && valid_a !== 1'b1; i++) step();
    check("stall_valid", valid_a, 1);
    for (int i = 0; i < 30 && sh_en_a !== 1'b0; i++) step();
    held = data_a;
    check("stall_first", held, 8'h34);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall_shen%0d", i), sh_en_a, 0);
      check($sformatf("stall_data%0d", i), data_a, 8'h34);
    end
    out_ready = 1'b1;
    wait_done(0, "stall_timeout");
    step();
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    check_words(0, w0, "stall");
    check("stall_shifts", sh_n_a - s0, 16);

    // chain restore: second readback depends on loopback
    preload(0, 16'hA5C3);
    w0 = words_a.size();
    run(0, "lb1_timeout");
    run(0, "lb2_timeout");
    step();
    exp_q.push_back(8'hC3); exp_q.push_back(8'hA5);
    exp_q.push_back(LB ? 8'hC3 : 8'h00); exp_q.push_back(LB ? 8'hA5 : 8'h00);
    check_words(0, w0, "lb");
    check("lb_chain", chain_a, LB ? 16'hA5C3 : 16'h0000);

    // start pulsed mid-readback is ignored
    preload(0, 16'hFF00);
    w0 = words_a.size(); s0 = sh_n_a;
    pulse_start(0);
    repeat (5) step();
    pulse_start(0);
    wait_done(0, "mid_timeout");
    step();
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    check_words(0, w0, "mid");
    check("mid_shifts", sh_n_a - s0, 16);

    // reset mid-SHIFT aborts with no done
    preload(0, 16'h5555);
    d0 = done_n_a;
    pulse_start(0);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rr_shen", sh_en_a, 0);
    check("rr_busy", busy_a, 0);
    check("rr_valid", valid_a, 0);
    check("rr_data", data_a, 0);
    check("rr_done", done_a, 0);
    check("rr_head", head_a, 0);
    reset = 1'b0;
    repeat (12) step();
    check("rr_no_done", done_n_a - d0, 0);
    check("rr_idle", busy_a, 0);

    // partial final word on instance b
    preload(1, 16'h03FF);
    w0 = words_b.size(); s0 = sh_n_b;
    run(1, "b_timeout");
    step();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h03);
    check_words(1, w0, "b");
    check("b_shifts", sh_n_b - s0, 10);
    check("b_done_n", done_n_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
